lotr: RTL and testbench

LOTR -- requirements
Module: lotr

---
 rtl/lotr.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_lotr.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lotr.sv
// UART-to-MMIO bridge: a host sends W/R/J/M commands over 8N1 serial to read and
// write a 16-word scratch RAM, the board LEDs, the seven-segment displays and a status word.
module lotr #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE         = 32'h03D02000
) (
    input  logic        QClk,
    input  logic        Button_0,
    input  logic        CLK_50,
    input  logic        Button_1,
    input  logic [9:0]  Switch,
    input  logic [15:0] Arduino_dg_io,
    input  logic        uart_master_tx,
    output logic        uart_master_rx,
    output logic        interrupt,
    output logic [7:0]  SEG7_0,
    output logic [7:0]  SEG7_1,
    output logic [7:0]  SEG7_2,
    output logic [7:0]  SEG7_3,
    output logic [7:0]  SEG7_4,
    output logic [7:0]  SEG7_5,
    output logic [3:0]  RED,
    output logic [3:0]  GREEN,
    output logic [3:0]  BLUE,
    output logic        v_sync,
    output logic        h_sync,
    output logic [9:0]  LED
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_J = 8'h4A;
    localparam logic [7:0] OP_M = 8'h4D;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SIZE, S_DATA, S_EXEC, S_RESP} cmd_state_t;

    logic        unused_ok;
    logic        rst;

    // ---------------- UART receiver ----------------
    rx_state_t   rx_state;
    logic        rx_s1, rx_s2, rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    // ---------------- UART transmitter ----------------
    logic        tx_busy;
    logic        tx_line;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_left;
    logic [8:0]  tx_shift;
    logic        tx_ready;
    logic        tx_load;
    logic [7:0]  tx_byte;

    // ---------------- command engine and registers ----------------
    cmd_state_t  state;
    logic [7:0]  opcode;
    logic [23:0] field;
    logic [31:0] next_field;
    logic [1:0]  byte_cnt;
    logic [31:0] addr;
    logic [29:0] count;
    logic [31:0] resp_word;
    logic [31:0] scratch [16];
    logic [9:0]  led;
    logic [7:0]  seg [6];

    logic [31:0] off;
    logic        in_ram, is_led, is_seg_lo, is_seg_hi, is_status;
    logic [3:0]  ram_idx;
    logic [31:0] rd_word;

    assign rst       = Button_0;
    assign unused_ok = ^{CLK_50, off[1:0]};

    always_ff @(posedge QClk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= uart_master_tx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A glitch shorter than half a bit is not a start bit.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= rx_shift;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Ready on the last cycle of a stop bit as well, so queued bytes go out with no gap.
    assign tx_ready = !tx_busy || (tx_cnt == BIT_LAST && tx_left == 4'd0);
    assign tx_load  = (state == S_RESP);
    assign tx_byte  = resp_word[31:24];

    always_ff @(posedge QClk) begin
        if (rst) begin
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_left  <= '0;
            tx_shift <= '0;
        end else if (tx_busy && tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 16'd1;
        end else if (tx_busy && tx_left != 4'd0) begin
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_left  <= tx_left - 4'd1;
            tx_cnt   <= '0;
        end else if (tx_load) begin
            tx_busy  <= 1'b1;
            tx_line  <= 1'b0;
            tx_shift <= {1'b1, tx_byte};
            tx_left  <= 4'd9;
            tx_cnt   <= '0;
        end else begin
            tx_busy <= 1'b0;
            tx_line <= 1'b1;
        end
    end

    assign uart_master_rx = tx_line;

    // Word-aligned decode relative to BASE; bits [1:0] of the address never matter.
    assign off       = addr - BASE;
    assign in_ram    = (off[31:6] == 26'd0);
    assign ram_idx   = off[5:2];
    assign is_led    = (off[31:2] == 30'h10);
    assign is_seg_lo = (off[31:2] == 30'h11);
    assign is_seg_hi = (off[31:2] == 30'h12);
    assign is_status = (off[31:2] == 30'h13);

    always_comb begin
        rd_word = '0;
        if (in_ram)         rd_word = scratch[ram_idx];
        else if (is_led)    rd_word = {22'd0, led};
        else if (is_seg_lo) rd_word = {seg[3], seg[2], seg[1], seg[0]};
        else if (is_seg_hi) rd_word = {16'd0, seg[5], seg[4]};
        else if (is_status) rd_word = {Arduino_dg_io, 4'b0000, Button_1, Switch, 1'b0};
    end

    assign next_field = {field, rx_byte};

    always_ff @(posedge QClk) begin
        if (rst) begin
            state     <= S_IDLE;
            opcode    <= '0;
            field     <= '0;
            byte_cnt  <= '0;
            addr      <= '0;
            count     <= '0;
            resp_word <= '0;
            interrupt <= 1'b0;
            led       <= '0;
            for (int i = 0; i < 6; i++)  seg[i]     <= 8'hFF;
            for (int i = 0; i < 16; i++) scratch[i] <= '0;
        end else begin
            interrupt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid && (rx_byte == OP_W || rx_byte == OP_R ||
                                     rx_byte == OP_J || rx_byte == OP_M)) begin
                        opcode   <= rx_byte;
                        byte_cnt <= '0;
                        count    <= 30'd1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        field    <= next_field[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            addr <= next_field;
                            if (opcode == OP_W)      state <= S_DATA;
                            else if (opcode == OP_R) state <= S_EXEC;
                            else                     state <= S_SIZE;
                        end
                    end
                end
                S_SIZE: begin
                    if (rx_valid) begin
                        field    <= next_field[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            count <= next_field[31:2];
                            if (next_field[31:2] == 30'd0) state <= S_IDLE;
                            else if (opcode == OP_J)      state <= S_DATA;
                            else                          state <= S_EXEC;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        field    <= next_field[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            interrupt <= 1'b1;
                            if (in_ram) begin
                                scratch[ram_idx] <= next_field;
                            end else if (is_led) begin
                                led <= next_field[9:0];
                            end else if (is_seg_lo) begin
                                seg[0] <= next_field[7:0];
                                seg[1] <= next_field[15:8];
                                seg[2] <= next_field[23:16];
                                seg[3] <= next_field[31:24];
                            end else if (is_seg_hi) begin
                                seg[4] <= next_field[7:0];
                                seg[5] <= next_field[15:8];
                            end
                            if (count == 30'd1) begin
                                state <= S_IDLE;
                            end else begin
                                count <= count - 30'd1;
                                addr  <= addr + 32'd4;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    resp_word <= rd_word;
                    byte_cnt  <= '0;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    // Incoming bytes are ignored here because only the states above consume rx_valid.
                    if (tx_ready) begin
                        resp_word <= {resp_word[23:0], 8'h00};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            addr <= addr + 32'd4;
                            if (count == 30'd1) begin
                                state <= S_IDLE;
                            end else begin
                                count <= count - 30'd1;
                                state <= S_EXEC;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign LED    = led;
    assign SEG7_0 = seg[0];
    assign SEG7_1 = seg[1];
    assign SEG7_2 = seg[2];
    assign SEG7_3 = seg[3];
    assign SEG7_4 = seg[4];
    assign SEG7_5 = seg[5];

    assign RED    = 4'd0;
    assign GREEN  = 4'd0;
    assign BLUE   = 4'd0;
    assign v_sync = 1'b1;
    assign h_sync = 1'b1;

endmodule

// File: tb/tb_lotr.sv
// Directed bench for lotr: drives serial commands, decodes the serial response
// and compares bytes, LEDs, displays and interrupt pulses with hand-computed values.
module tb_lotr;

    localparam int BIT = 8;

    logic        QClk = 1'b0;
    logic        CLK_50;
    logic        Button_0 = 1'b1;
    logic        Button_1 = 1'b0;
    logic [9:0]  Switch = '0;
    logic [15:0] Arduino_dg_io = '0;
    logic        uart_master_tx = 1'b1;
    logic        uart_master_rx;
    logic        interrupt;
    logic [7:0]  SEG7_0, SEG7_1, SEG7_2, SEG7_3, SEG7_4, SEG7_5;
    logic [3:0]  RED, GREEN, BLUE;
    logic        v_sync, h_sync;
    logic [9:0]  LED;

    int passed = 0;
    int total  = 0;
    int irq_cnt = 0;
    int irq0;
    int cyc = 0;
    int gap;
    int t;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         start_q[$];

    always #5 QClk = ~QClk;
    assign CLK_50 = QClk;

    lotr #(.CLKS_PER_BIT(BIT), .BASE(32'h03D02000)) dut (
        .QClk(QClk), .Button_0(Button_0), .CLK_50(CLK_50), .Button_1(Button_1),
        .Switch(Switch), .Arduino_dg_io(Arduino_dg_io),
        .uart_master_tx(uart_master_tx), .uart_master_rx(uart_master_rx),
        .interrupt(interrupt),
        .SEG7_0(SEG7_0), .SEG7_1(SEG7_1), .SEG7_2(SEG7_2),
        .SEG7_3(SEG7_3), .SEG7_4(SEG7_4), .SEG7_5(SEG7_5),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .v_sync(v_sync), .h_sync(h_sync), .LED(LED)
    );

    always @(posedge QClk) cyc++;
    always @(negedge QClk) if (interrupt === 1'b1) irq_cnt++;

    // Serial monitor on uart_master_rx: mid-bit sampling, bytes into got_q.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge QClk);
            if (uart_master_rx === 1'b0) begin
                repeat (BIT / 2) @(negedge QClk);
                if (uart_master_rx === 1'b0) begin
                    start_q.push_back(cyc);
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge QClk);
                        b[i] = uart_master_rx;
                    end
                    repeat (BIT) @(negedge QClk);
                    got_q.push_back(b);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
        @(negedge QClk);
        uart_master_tx = 1'b0;
        repeat (BIT) @(negedge QClk);
        for (int i = 0; i < 8; i++) begin
            uart_master_tx = b[i];
            repeat (BIT) @(negedge QClk);
        end
        uart_master_tx = stop_ok;
        repeat (BIT) @(negedge QClk);
        if (!stop_ok) begin
            uart_master_tx = 1'b1;
            repeat (2 * BIT) @(negedge QClk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57);
        send_word(a);
        send_word(d);
        repeat (4) @(negedge QClk);
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic check_resp(input string tag);
        int n;
        int waited;
        logic [7:0] o;
        n = exp_q.size();
        waited = 0;
        while (got_q.size() < n && waited < n * BIT * 12 + 400) begin
            @(negedge QClk);
            waited++;
        end
        for (int i = 0; i < n; i++) begin
            o = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            check(tag, 48'(o), 48'(exp_q.pop_front()));
        end
        repeat (BIT) @(negedge QClk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge QClk);
        Button_0 = 1'b0;
        @(negedge QClk);
        check("reset_tx", 48'(uart_master_rx), 48'd1);
        check("reset_irq", 48'(interrupt), 48'd0);
        check("reset_led", 48'(LED), 48'd0);
        check("reset_seg", {SEG7_5, SEG7_4, SEG7_3, SEG7_2, SEG7_1, SEG7_0}, 48'hFFFF_FFFF_FFFF);
        check("vga_const", 48'({RED, GREEN, BLUE, v_sync, h_sync}), 48'h3);

        // Single write then read-back of scratch
        irq0 = irq_cnt;
        do_write(32'h03D02018, 32'hDEADBEEF);
        check("w_irq", 48'(irq_cnt - irq0), 48'd1);
        send_byte(8'h52);
        send_word(32'h03D02018);
        expect_word(32'hDEADBEEF);
        check_resp("r_scratch");

        // LED and display registers
        do_write(32'h03D02040, 32'h000003FF);
        check("led_write", 48'(LED), 48'h3FF);
        do_write(32'h03D02044, 32'hC0F9A4B0);
        check("seg_lo", 48'({SEG7_3, SEG7_2, SEG7_1, SEG7_0}), 48'hC0F9A4B0);
        send_byte(8'h52);
        send_word(32'h03D02040);
        expect_word(32'h000003FF);
        check_resp("r_led");

        // Burst write of three words, burst read back, responses back-to-back
        irq0 = irq_cnt;
        send_byte(8'h4A);
        send_word(32'h03D02000);
        send_word(32'h0000000C);
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_word(32'h99AABBCC);
        repeat (4) @(negedge QClk);
        check("j_irq", 48'(irq_cnt - irq0), 48'd3);
        start_q.delete();
        send_byte(8'h4D);
        send_word(32'h03D02000);
        send_word(32'h0000000C);
        expect_word(32'h11223344);
        expect_word(32'h55667788);
        expect_word(32'h99AABBCC);
        check_resp("m_burst");
        gap = (start_q.size() >= 12) ? start_q[11] - start_q[0] : -1;
        check("m_back_to_back", 48'(gap), 48'(11 * 10 * BIT));

        // Non-opcode byte ignored, unmapped read returns zero
        send_byte(8'h41);
        repeat (20 * BIT) @(negedge QClk);
        check("ignore_A", 48'(got_q.size()), 48'd0);
        send_byte(8'h52);
        send_word(32'h00000000);
        expect_word(32'h00000000);
        check_resp("r_unmapped");

        // Status word
        Switch = 10'h2A5;
        Button_1 = 1'b1;
        Arduino_dg_io = 16'hBEEF;
        send_byte(8'h52);
        send_word(32'h03D0204C);
        expect_word(32'hBEEF0D4A);
        check_resp("r_status");

        // Reset in the middle of a response: line back to idle at once
        send_byte(8'h52);
        send_word(32'h03D0204C);
        t = 0;
        while (uart_master_rx !== 1'b0 && t < 40 * BIT) begin
            @(negedge QClk);
            t++;
        end
        check("tx_started", 48'(uart_master_rx), 48'd0);
        repeat (3) @(negedge QClk);
        Button_0 = 1'b1;
        @(posedge QClk);
        #1;
        check("tx_abort_idle", 48'(uart_master_rx), 48'd1);
        @(negedge QClk);
        Button_0 = 1'b0;
        repeat (12 * BIT) @(negedge QClk);
        got_q.delete();
        start_q.delete();
        check("tx_abort_led", 48'(LED), 48'd0);

        // Zero-length burst completes at once; next W is parsed normally
        irq0 = irq_cnt;
        send_byte(8'h4A);
        send_word(32'h03D02000);
        send_word(32'h00000003);
        do_write(32'h03D02048, 32'h0000A1A2);
        check("zero_burst_seg", 48'({SEG7_5, SEG7_4}), 48'hA1A2);
        check("zero_burst_irq", 48'(irq_cnt - irq0), 48'd1);

        // Framing error during the address phase
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'h55, 1'b0);
        send_byte(8'hD0);
        send_byte(8'h20);
        send_byte(8'h48);
        send_word(32'h0000B3B4);
        repeat (4) @(negedge QClk);
        check("framing_seg", 48'({SEG7_5, SEG7_4}), 48'hB3B4);

        // Reset after 5 of 9 W bytes: no write, registers back to reset values
        do_write(32'h03D02040, 32'h000002AA);
        check("led_before_abort", 48'(LED), 48'h2AA);
        irq0 = irq_cnt;
        send_byte(8'h57);
        send_word(32'h03D02040);
        @(negedge QClk);
        Button_0 = 1'b1;
        repeat (2) @(negedge QClk);
        Button_0 = 1'b0;
        send_word(32'h00000155);
        repeat (4) @(negedge QClk);
        check("abort_irq", 48'(irq_cnt - irq0), 48'd0);
        check("abort_led", 48'(LED), 48'd0);
        check("abort_seg", {SEG7_5, SEG7_4, SEG7_3, SEG7_2, SEG7_1, SEG7_0}, 48'hFFFF_FFFF_FFFF);
        do_write(32'h03D02040, 32'h00000155);
        check("after_abort_led", 48'(LED), 48'h155);
        check("after_abort_irq", 48'(irq_cnt - irq0), 48'd1);

        // Scratch cleared by reset; burst read crossing RAM end into LED
        send_byte(8'h52);
        send_word(32'h03D02018);
        expect_word(32'h00000000);
        check_resp("r_scratch_cleared");
        send_byte(8'h4D);
        send_word(32'h03D0203C);
        send_word(32'h00000008);
        expect_word(32'h00000000);
        expect_word(32'h00000155);
        check_resp("m_cross");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
